// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding and bubble counter
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [8:0]       id_ctrl,
    input  logic [4:0]       mem_fwd_addr,
    input  logic [31:0]      mem_fwd_data,
    input  logic [4:0]       wb_fwd_addr,
    input  logic [31:0]      wb_fwd_data,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_control,
    output logic [31:0]      ex_store_data,
    output logic [4:0]       ex_write_reg,
    output logic [2:0]       ex_ctrl,
    output logic             ex_valid,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic        valid_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [8:0]  ctrl_q;
    logic [31:0] rs_res;
    logic [31:0] rt_res;

    // Flush wins over hold; an empty ID slot also becomes a bubble but is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else if (flush || (!hold && !id_valid)) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
        end else if (!hold) begin
            valid_q   <= 1'b1;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rd_q      <= id_rd;
            ctrl_q    <= id_ctrl;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (flush && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    // Forwarding stays live while held; register 0 is never forwarded.
    always_comb begin
        rs_res = rs_data_q;
        if ((rs_q != 5'd0) && (rs_q == mem_fwd_addr)) begin
            rs_res = mem_fwd_data;
        end else if ((rs_q != 5'd0) && (rs_q == wb_fwd_addr)) begin
            rs_res = wb_fwd_data;
        end
        rt_res = rt_data_q;
        if ((rt_q != 5'd0) && (rt_q == mem_fwd_addr)) begin
            rt_res = mem_fwd_data;
        end else if ((rt_q != 5'd0) && (rt_q == wb_fwd_addr)) begin
            rt_res = wb_fwd_data;
        end
    end

    always_comb begin
        ex_write_reg = 5'd0;
        ex_ctrl      = ctrl_q[2:0];
        case (ctrl_q[4:3])
            2'b00:   ex_write_reg = rt_q;
            2'b01:   ex_write_reg = rd_q;
            2'b10:   ex_write_reg = 5'd31;
            default: begin
                ex_write_reg = 5'd0;
                ex_ctrl[2]   = 1'b0;
            end
        endcase
    end

    assign alu_a         = rs_res;
    assign alu_b         = ctrl_q[5] ? imm_q : rt_res;
    assign alu_control   = ctrl_q[8:6];
    assign ex_store_data = rt_res;
    assign ex_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage against a behavioural pipeline model
module tb_id_ex_stage;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hold = 1'b0;
    logic             flush = 1'b0;
    logic             id_valid = 1'b0;
    logic [31:0]      id_rs_data = '0;
    logic [31:0]      id_rt_data = '0;
    logic [31:0]      id_imm = '0;
    logic [4:0]       id_rs = '0;
    logic [4:0]       id_rt = '0;
    logic [4:0]       id_rd = '0;
    logic [8:0]       id_ctrl = '0;
    logic [4:0]       mem_fwd_addr = '0;
    logic [31:0]      mem_fwd_data = '0;
    logic [4:0]       wb_fwd_addr = '0;
    logic [31:0]      wb_fwd_data = '0;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_control;
    logic [31:0]      ex_store_data;
    logic [4:0]       ex_write_reg;
    logic [2:0]       ex_ctrl;
    logic             ex_valid;
    logic [CNT_W-1:0] bubble_cnt;

    int n_pass = 0;
    int n_total = 0;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_ctrl(id_ctrl),
        .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: the instruction sitting in EX, or none.
    bit          m_valid;
    logic [31:0] m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [8:0]  m_ctrl;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_rsd <= 0; m_rtd <= 0; m_imm <= 0;
            m_rs <= 0; m_rt <= 0; m_rd <= 0; m_ctrl <= 0; m_cnt <= 0;
        end else begin
            if (flush) m_cnt <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            if (flush || (!hold && !id_valid)) begin
                m_valid <= 0; m_rsd <= 0; m_rtd <= 0; m_imm <= 0;
                m_rs <= 0; m_rt <= 0; m_rd <= 0; m_ctrl <= 0;
            end else if (!hold) begin
                m_valid <= 1; m_rsd <= id_rs_data; m_rtd <= id_rt_data; m_imm <= id_imm;
                m_rs <= id_rs; m_rt <= id_rt; m_rd <= id_rd; m_ctrl <= id_ctrl;
            end
        end
    end

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] cap);
        if (r == 0) return cap;
        if (r == mem_fwd_addr) return mem_fwd_data;
        if (r == wb_fwd_addr) return wb_fwd_data;
        return cap;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            logic [4:0] wr;
            logic       rw;
            rw = m_ctrl[2];
            case (m_ctrl[4:3])
                2'd0: wr = m_rt;
                2'd1: wr = m_rd;
                2'd2: wr = 5'd31;
                default: begin wr = 5'd0; rw = 1'b0; end
            endcase
            check("m_alu_a", alu_a, operand(m_rs, m_rsd));
            check("m_alu_b", alu_b, m_ctrl[5] ? m_imm : operand(m_rt, m_rtd));
            check("m_store", ex_store_data, operand(m_rt, m_rtd));
            check("m_aluctl", 32'(alu_control), 32'(m_ctrl[8:6]));
            check("m_wreg", 32'(ex_write_reg), 32'(wr));
            check("m_ctrl", 32'(ex_ctrl), 32'({rw, m_ctrl[1:0]}));
            check("m_valid", 32'(ex_valid), 32'(m_valid));
            check("m_cnt", 32'(bubble_cnt), m_cnt[31:0]);
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] rs, input logic [31:0] rsd, input logic [4:0] rt,
                        input logic [31:0] rtd, input logic [4:0] rd, input logic [31:0] imm,
                        input logic [8:0] ctrl);
        id_valid = 1; id_rs = rs; id_rs_data = rsd; id_rt = rt; id_rt_data = rtd;
        id_rd = rd; id_imm = imm; id_ctrl = ctrl;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, alu_a, 0);
        check({tag, "_b"}, alu_b, 0);
        check({tag, "_st"}, ex_store_data, 0);
        check({tag, "_ctl"}, 32'(alu_control), 0);
        check({tag, "_wr"}, 32'(ex_write_reg), 0);
        check({tag, "_ec"}, 32'(ex_ctrl), 0);
        check({tag, "_v"}, 32'(ex_valid), 0);
    endtask

    initial begin
        #12;
        check_zero("reset");
        check("reset_cnt", 32'(bubble_cnt), 0);
        @(negedge clk); #1; rst_n = 1;

        // addu r10 = r8 + r9
        load(5'd8, 32'd5, 5'd9, 32'd7, 5'd10, 32'h0, 9'b010_0_01_100);
        cycle();
        check("addu_a", alu_a, 5);
        check("addu_b", alu_b, 7);
        check("addu_ctl", 32'(alu_control), 32'b010);
        check("addu_wr", 32'(ex_write_reg), 10);
        check("addu_ec", 32'(ex_ctrl), 32'b100);
        check("addu_v", 32'(ex_valid), 1);

        // forwarding priority on the held addu (rs=8)
        hold = 1;
        mem_fwd_addr = 8; mem_fwd_data = 32'h11; wb_fwd_addr = 8; wb_fwd_data = 32'h22;
        #1 check("fwd_mem", alu_a, 32'h11);
        mem_fwd_addr = 0;
        #1 check("fwd_wb", alu_a, 32'h22);
        hold = 0; wb_fwd_addr = 0; mem_fwd_data = 32'h99;
        load(5'd0, 32'h55, 5'd0, 32'h66, 5'd1, 32'h0, 9'b000_0_00_100);
        cycle();
        check("fwd_r0_a", alu_a, 32'h55);
        check("fwd_r0_st", ex_store_data, 32'h66);

        // ori: immediate on B, store data still forwarded rt
        wb_fwd_addr = 9; wb_fwd_data = 32'hAB;
        load(5'd8, 32'd1, 5'd9, 32'd7, 5'd0, 32'h0000FFFF, 9'b001_1_00_100);
        cycle();
        check("ori_b", alu_b, 32'h0000FFFF);
        check("ori_st", ex_store_data, 32'hAB);
        check("ori_wr", 32'(ex_write_reg), 9);

        // held instruction tracks WB value on rs
        wb_fwd_addr = 3; wb_fwd_data = 32'd0;
        load(5'd3, 32'h77, 5'd4, 32'h44, 5'd5, 32'h0, 9'b110_0_01_100);
        cycle();
        hold = 1;
        id_rs_data = 32'hDEAD; id_ctrl = 9'b111_1_10_011;
        for (int k = 1; k <= 3; k++) begin
            wb_fwd_data = k;
            cycle();
            check("hold_a", alu_a, k);
            check("hold_ctl", 32'(alu_control), 32'b110);
            check("hold_cnt", 32'(bubble_cnt), 0);
        end
        hold = 0; wb_fwd_addr = 0;

        // reg_dst 10 -> r31, 11 -> r0 with reg_write suppressed
        load(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 9'b010_0_10_100);
        cycle();
        check("jal_wr", 32'(ex_write_reg), 31);
        load(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 9'b010_0_11_111);
        cycle();
        check("rd11_wr", 32'(ex_write_reg), 0);
        check("rd11_ec", 32'(ex_ctrl), 32'b011);

        // empty ID slot: bubble, not counted
        id_valid = 0;
        cycle();
        check_zero("idle");
        check("idle_cnt", 32'(bubble_cnt), 0);

        // flush beats hold
        load(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, 9'b010_0_01_100);
        cycle();
        hold = 1; flush = 1;
        cycle();
        check("flush_v", 32'(ex_valid), 0);
        check("flush_ec", 32'(ex_ctrl), 0);
        check("flush_cnt", 32'(bubble_cnt), 1);
        hold = 0;
        for (int k = 0; k < CNT_MAX + 3; k++) cycle();
        check("sat_cnt", 32'(bubble_cnt), CNT_MAX);
        flush = 0;

        // asynchronous reset between edges with a held valid instruction
        load(5'd6, 32'h1234, 5'd7, 32'h5678, 5'd8, 32'h9, 9'b010_1_01_110);
        cycle();
        check("pre_rst_v", 32'(ex_valid), 1);
        hold = 1;
        #2 rst_n = 0;
        #1;
        check_zero("arst");
        check("arst_cnt", 32'(bubble_cnt), 0);
        @(negedge clk); #1; rst_n = 1; hold = 0;
        cycle();
        check("resume_v", 32'(ex_valid), 1);
        check("resume_a", alu_a, 32'h1234);
        id_valid = 0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of bubble_cnt.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port hold  input  1  1 = keep current EX contents (EX-side stall).
REQ-005 SHALL have port flush  input  1  1 = load a bubble (load-use or branch kill).
REQ-006 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-007 SHALL have port id_rs_data  input  32  GPR[rs] read in ID.
REQ-008 SHALL have port id_rt_data  input  32  GPR[rt] read in ID.
REQ-009 SHALL have port id_imm  input  32  extended immediate (zero/sign/lui-shifted, done in ID).
REQ-010 SHALL have ports id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-011 SHALL have port id_ctrl  input  9  {alu_control[2:0], alu_src, reg_dst[1:0], reg_write, mem_write, mem_to_reg}.
REQ-012 SHALL have ports mem_fwd_addr  input  5, mem_fwd_data  input  32  MEM-stage result; addr 0 = nothing to forward.
REQ-013 SHALL have ports wb_fwd_addr  input  5, wb_fwd_data  input  32  WB-stage result; addr 0 = nothing to forward.
REQ-014 SHALL have ports alu_a, alu_b  output  32 each  ALU operands.
REQ-015 SHALL have port alu_control  output  3  ALU opcode (000 and, 001 or, 010 addu, 110 subu, 111 slt).
REQ-016 SHALL have port ex_store_data  output  32  forwarded rt value for sw.
REQ-017 SHALL have port ex_write_reg  output  5  destination register.
REQ-018 SHALL have port ex_ctrl  output  3  {reg_write, mem_write, mem_to_reg}.
REQ-019 SHALL have ports ex_valid  output  1, bubble_cnt  output  CNT_W  bubbles inserted.

Function
REQ-020 SHALL, on each rising clk with flush=0 and hold=0, capture all id_* inputs into the EX register set.
REQ-021 SHALL, on a rising clk with flush=1, load a bubble regardless of hold: ex_valid=0, all control fields 0, all data and specifier fields 0.
REQ-022 SHALL, on a rising clk with id_valid=0, flush=0, hold=0, load a bubble identical to REQ-021 without incrementing bubble_cnt.
REQ-023 SHALL, on a rising clk with hold=1 and flush=0, retain every registered field unchanged.
REQ-024 SHALL resolve each source operand combinationally from the registered specifier: MEM match (nonzero addr equal) first, else WB match, else the captured register data.
REQ-025 SHALL never forward to specifier 0; operand for register 0 is always the captured value.
REQ-026 SHALL keep forwarding live during hold, so a held instruction sees new MEM/WB values each cycle.
REQ-027 SHALL drive alu_a = resolved rs; alu_b = id_imm when captured alu_src=1, else resolved rt.
REQ-028 SHALL drive ex_store_data = resolved rt regardless of alu_src.
REQ-029 SHALL drive ex_write_reg from captured reg_dst: 00 rt, 01 rd, 10 5'd31, 11 5'd0 with reg_write forced 0.
REQ-030 SHALL increment bubble_cnt by 1 on each rising clk with flush=1, saturating at all-ones.
REQ-031 SHALL have one-cycle latency from ID capture to outputs; no combinational path from id_* to any output.

Reset
REQ-032 SHALL, while rst_n=0, immediately and asynchronously force every register to 0: ex_valid=0, ex_ctrl=0, alu_control=000, ex_write_reg=0, bubble_cnt=0; with fwd addrs 0, alu_a=alu_b=ex_store_data=0.
REQ-033 SHALL resume capture on the first rising clk after rst_n returns high; reset mid-hold or mid-flush discards the held instruction.

Verification
REQ-034 SHALL pass: addu rs=8 (5), rt=9 (7), rd=10, reg_dst=01, no fwd -> next cycle alu_a=5, alu_b=7, alu_control=010, ex_write_reg=10, ex_ctrl=100, ex_valid=1.
REQ-035 SHALL pass: captured rs=8, mem_fwd 8/0x11, wb_fwd 8/0x22 -> alu_a=0x11; mem_fwd_addr=0 -> alu_a=0x22; rs=0 with both addrs 0 -> captured value.
REQ-036 SHALL pass: ori with alu_src=1, id_imm=0x0000FFFF, rt=9, wb_fwd 9/0xAB -> alu_b=0x0000FFFF, ex_store_data=0xAB.
REQ-037 SHALL pass: hold=1 for 3 cycles while wb_fwd_data steps 1,2,3 on rs -> registered fields unchanged, alu_a follows 1,2,3, bubble_cnt unchanged.
REQ-038 SHALL pass: flush=1 and hold=1 on same edge -> ex_valid=0, ex_ctrl=0, bubble_cnt +1; after 2^CNT_W+2 flushes bubble_cnt stays all-ones.
REQ-039 SHALL pass: rst_n pulled low between edges with valid instruction held -> all outputs 0 before next edge, ex_valid=0.
